// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - pixel-rate divider, scan counters and registered VGA sync/blanking
module vga_sync_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int SYNC_POL  = 0
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_BEG   = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_BEG   = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);
    localparam logic       SYNC_ACT = (SYNC_POL != 0);

    logic [3:0] div_cnt;
    logic [9:0] x_next;
    logic [9:0] y_next;

    assign p_tick      = (div_cnt == DIV_LAST);
    assign frame_start = p_tick && (x == H_LAST) && (y == V_LAST);

    always_comb begin
        x_next = x;
        y_next = y;
        if (p_tick) begin
            if (x == H_LAST) begin
                x_next = '0;
                y_next = (y == V_LAST) ? '0 : y + 10'd1;
            end else begin
                x_next = x + 10'd1;
            end
        end
    end

    // Sync/blank registers are fed from x_next/y_next so they stay aligned with x/y.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt  <= '0;
            x        <= '0;
            y        <= '0;
            video_on <= 1'b1;
            hsync    <= ~SYNC_ACT;
            vsync    <= ~SYNC_ACT;
        end else begin
            div_cnt  <= p_tick ? 4'd0 : div_cnt + 4'd1;
            x        <= x_next;
            y        <= y_next;
            video_on <= (x_next < H_VIS) && (y_next < V_VIS);
            hsync    <= ((x_next >= HS_BEG) && (x_next < HS_END)) ? SYNC_ACT : ~SYNC_ACT;
            vsync    <= ((y_next >= VS_BEG) && (y_next < VS_END)) ? SYNC_ACT : ~SYNC_ACT;
        end
    end
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - directed checks of vga_sync_gen at default and reduced timings
module tb_vga_sync_gen;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       p_tick, video_on, hsync, vsync, frame_start;
    logic [9:0] x, y;
    logic       s_p_tick, s_video_on, s_hsync, s_vsync, s_frame_start;
    logic [9:0] s_x, s_y;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    vga_sync_gen u_dut (
        .clk(clk), .reset(reset), .p_tick(p_tick), .x(x), .y(y),
        .video_on(video_on), .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
    );

    // Reduced timing: 16x10 total, 8x6 visible, active-high sync, divide by 2.
    vga_sync_gen #(
        .CLK_DIV(2), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_POL(1)
    ) u_small (
        .clk(clk), .reset(reset), .p_tick(s_p_tick), .x(s_x), .y(s_y),
        .video_on(s_video_on), .hsync(s_hsync), .vsync(s_vsync), .frame_start(s_frame_start)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int hs_px, vs_px, vo_px, fs_n, fs_at0, fs_at1;
        logic found;

        // Asynchronous reset, checked before any clock edge
        #1 reset = 1'b1;
        #1;
        chk("rst_ptick", p_tick, 0);
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_video_on", video_on, 1);
        chk("rst_hsync", hsync, 1);
        chk("rst_vsync", vsync, 1);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_s_hsync", s_hsync, 0);
        chk("rst_s_vsync", s_vsync, 0);
        @(negedge clk);
        reset = 1'b0;

        // First line at default timing
        hs_px = 0; vs_px = 0; vo_px = 0; fs_n = 0;
        for (int k = 1; k <= 3200; k++) begin
            @(negedge clk);
            if (k <= 40) begin
                chk("t1_ptick", p_tick, (k % 4 == 3) ? 1 : 0);
                chk("t1_x", x, k / 4);
                chk("t1_y", y, 0);
            end
            if (frame_start) fs_n++;
            if (p_tick) begin
                if (!hsync) hs_px++;
                if (!vsync) vs_px++;
                if (video_on) vo_px++;
                if (x == 10'd639) chk("vo_x639", video_on, 1);
                if (x == 10'd640) chk("vo_x640", video_on, 0);
                if (x == 10'd655) chk("hs_x655", hsync, 1);
                if (x == 10'd656) chk("hs_x656", hsync, 0);
                if (x == 10'd751) chk("hs_x751", hsync, 0);
                if (x == 10'd752) chk("hs_x752", hsync, 1);
            end
            if (k == 3199) begin
                chk("line_end_x", x, 799);
                chk("line_end_y", y, 0);
                chk("line_end_ptick", p_tick, 1);
            end
        end
        chk("wrap_x", x, 0);
        chk("wrap_y", y, 1);
        chk("wrap_ptick", p_tick, 0);
        chk("hsync_px", hs_px, 96);
        chk("vsync_px_line0", vs_px, 0);
        chk("video_on_px_line0", vo_px, 640);
        chk("no_frame_start_line0", fs_n, 0);

        // Reset mid-line while hsync is active
        found = 1'b0;
        for (int k = 0; k < 4000 && !found; k++) begin
            @(negedge clk);
            if (x == 10'd700) found = 1'b1;
        end
        chk("reach_x700", found, 1);
        chk("pre_rst_hsync", hsync, 0);
        chk("pre_rst_y", y, 1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_x", x, 0);
        chk("mid_rst_y", y, 0);
        chk("mid_rst_hsync", hsync, 1);
        chk("mid_rst_vsync", vsync, 1);
        chk("mid_rst_ptick", p_tick, 0);
        chk("mid_rst_video_on", video_on, 1);
        @(negedge clk);
        reset = 1'b0;

        // Two full frames of the reduced-timing instance
        hs_px = 0; vs_px = 0; vo_px = 0; fs_n = 0; fs_at0 = 0; fs_at1 = 0;
        for (int k = 1; k <= 640; k++) begin
            @(negedge clk);
            if (s_frame_start) begin
                if (fs_n == 0) fs_at0 = k;
                if (fs_n == 1) fs_at1 = k;
                fs_n++;
                chk("fs_x", s_x, 15);
                chk("fs_y", s_y, 9);
                chk("fs_ptick", s_p_tick, 1);
            end
            if (s_p_tick) begin
                if (s_hsync) hs_px++;
                if (s_vsync) vs_px++;
                if (s_video_on) vo_px++;
                if (s_x == 10'd8) chk("s_vo_x8", s_video_on, 0);
                if (s_y == 10'd6) chk("s_vo_y6", s_video_on, 0);
            end
        end
        chk("fs_count", fs_n, 2);
        chk("fs_first_clk", fs_at0, 319);
        chk("fs_second_clk", fs_at1, 639);
        chk("s_hsync_px", hs_px, 60);
        chk("s_vsync_px", vs_px, 64);
        chk("s_video_on_px", vo_px, 96);
        chk("s_frame_wrap_x", s_x, 0);
        chk("s_frame_wrap_y", s_y, 0);

        // Reset during the reduced instance's vsync pulse
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            @(negedge clk);
            if (s_y == 10'd7 && s_x == 10'd3) found = 1'b1;
        end
        chk("reach_s_y7", found, 1);
        chk("pre_rst_s_vsync", s_vsync, 1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("s_rst_x", s_x, 0);
        chk("s_rst_y", s_y, 0);
        chk("s_rst_vsync", s_vsync, 0);
        chk("s_rst_hsync", s_hsync, 0);
        chk("s_rst_ptick", s_p_tick, 0);
        chk("s_rst_frame_start", s_frame_start, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("s_post_rst_ptick", s_p_tick, 1);
        chk("s_post_rst_x", s_x, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
